// File: rtl/ctrl_act_seq.sv
// Activation fetch sequencer: six nested counters (act/row/blk/frm/pat/lay) stepped once per accepted fetch.
// Optional pooling controls are built only when CTRL_ACT_SEQ_POOL_EN is defined.
module ctrl_act_seq #(
    parameter int ROW_W    = 5,
    parameter int BLK_W    = 4,
    parameter int FRM_W    = 4,
    parameter int PAT_W    = 6,
    parameter int LAY_W    = 5,
    parameter int COL_SKIP = 2,
    parameter int ROW_SKIP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] cfg_len_row,
    input  logic [ROW_W-1:0] cfg_num_row,
    input  logic [BLK_W-1:0] cfg_num_blk,
    input  logic [FRM_W-1:0] cfg_num_frm,
    input  logic [PAT_W-1:0] cfg_num_pat,
    input  logic [LAY_W-1:0] cfg_num_lay,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic             frt_row,
    output logic             lst_row,
    output logic             frt_blk,
    output logic             lst_blk,
    output logic             val_col,
    output logic             val_psum,
    output logic             even_frm,
    output logic             fnh_frm,
    output logic             fnh_pat,
    output logic             fnh_lay,
    output logic             busy,
    output logic             done,
    output logic             pool_en,
    output logic             pool_val_delta,
    output logic             pool_val_frm
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [ROW_W-1:0] act, row, len_row, num_row;
    logic [BLK_W-1:0] blk, num_blk;
    logic [FRM_W-1:0] frm, num_frm;
    logic [PAT_W-1:0] pat, num_pat;
    logic [LAY_W-1:0] lay, num_lay;
    logic             wrap_act, wrap_row, wrap_blk, wrap_frm, wrap_pat, wrap_lay;

    // Each wrap term means "this level and every inner level are at their max".
    always_comb begin
        wrap_act = (act == len_row);
        wrap_row = wrap_act && (row == num_row);
        wrap_blk = wrap_row && (blk == num_blk);
        wrap_frm = wrap_blk && (frm == num_frm);
        wrap_pat = wrap_frm && (pat == num_pat);
        wrap_lay = wrap_pat && (lay == num_lay);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            act     <= '0;
            row     <= '0;
            blk     <= '0;
            frm     <= '0;
            pat     <= '0;
            lay     <= '0;
            len_row <= '0;
            num_row <= '0;
            num_blk <= '0;
            num_frm <= '0;
            num_pat <= '0;
            num_lay <= '0;
            fnh_frm <= 1'b0;
            fnh_pat <= 1'b0;
            fnh_lay <= 1'b0;
        end else begin
            fnh_frm <= 1'b0;
            fnh_pat <= 1'b0;
            fnh_lay <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_row <= cfg_len_row;
                        num_row <= cfg_num_row;
                        num_blk <= cfg_num_blk;
                        num_frm <= cfg_num_frm;
                        num_pat <= cfg_num_pat;
                        num_lay <= cfg_num_lay;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a same-cycle fetch and suppresses every pulse.
                    if (abort) begin
                        state <= IDLE;
                        act   <= '0;
                        row   <= '0;
                        blk   <= '0;
                        frm   <= '0;
                        pat   <= '0;
                        lay   <= '0;
                    end else if (fetch_ack) begin
                        act <= wrap_act ? '0 : act + 1'b1;
                        if (wrap_act) row <= wrap_row ? '0 : row + 1'b1;
                        if (wrap_row) blk <= wrap_blk ? '0 : blk + 1'b1;
                        if (wrap_blk) frm <= wrap_frm ? '0 : frm + 1'b1;
                        if (wrap_frm) pat <= wrap_pat ? '0 : pat + 1'b1;
                        if (wrap_pat) lay <= wrap_lay ? '0 : lay + 1'b1;
                        fnh_frm <= wrap_blk;
                        fnh_pat <= wrap_frm;
                        fnh_lay <= wrap_pat;
                        if (wrap_lay) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign fetch_req = busy;
    assign done      = (state == DONE);

    assign frt_row  = busy && (act == '0);
    assign lst_row  = busy && wrap_act;
    assign frt_blk  = busy && (blk == '0);
    assign lst_blk  = busy && wrap_row;
    assign val_col  = busy && (act >= ROW_W'(COL_SKIP));
    assign val_psum = busy && (row >= ROW_W'(ROW_SKIP));
    assign even_frm = busy && !frm[0];

`ifdef CTRL_ACT_SEQ_POOL_EN
    assign pool_en        = busy && (blk != '0) && (frm != '0) && (act == '0) && (row == '0);
    assign pool_val_delta = busy && (frm >= FRM_W'(2));
    assign pool_val_frm   = busy && !frm[0] && (frm >= FRM_W'(2));
`else
    assign pool_en        = 1'b0;
    assign pool_val_delta = 1'b0;
    assign pool_val_frm   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_act_seq.sv
// Bench for ctrl_act_seq: directed and randomized runs checked against a fetch-count reference model.
// Pool expectations follow CTRL_ACT_SEQ_POOL_EN the same way the design does.
module tb_ctrl_act_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, fetch_ack;
    logic [4:0] cfg_len_row, cfg_num_row, cfg_num_lay;
    logic [3:0] cfg_num_blk, cfg_num_frm;
    logic [5:0] cfg_num_pat;
    logic       fetch_req, frt_row, lst_row, frt_blk, lst_blk, val_col, val_psum, even_frm;
    logic       fnh_frm, fnh_pat, fnh_lay, busy, done, pool_en, pool_val_delta, pool_val_frm;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the run is a count k of accepted fetches; positions are mixed-radix digits of k.
    int m_state;
    int m_k;
    int m_l, m_r, m_b, m_f, m_p, m_n;
    bit m_fnh_frm, m_fnh_pat, m_fnh_lay;

    ctrl_act_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_len_row(cfg_len_row), .cfg_num_row(cfg_num_row), .cfg_num_blk(cfg_num_blk),
        .cfg_num_frm(cfg_num_frm), .cfg_num_pat(cfg_num_pat), .cfg_num_lay(cfg_num_lay),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .frt_row(frt_row), .lst_row(lst_row), .frt_blk(frt_blk), .lst_blk(lst_blk),
        .val_col(val_col), .val_psum(val_psum), .even_frm(even_frm),
        .fnh_frm(fnh_frm), .fnh_pat(fnh_pat), .fnh_lay(fnh_lay),
        .busy(busy), .done(done),
        .pool_en(pool_en), .pool_val_delta(pool_val_delta), .pool_val_frm(pool_val_frm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_k = 0;
        m_l = 1; m_r = 1; m_b = 1; m_f = 1; m_p = 1; m_n = 1;
        m_fnh_frm = 0; m_fnh_pat = 0; m_fnh_lay = 0;
    endtask

    task automatic model_update(input bit s, input bit a, input bit ab);
        m_fnh_frm = 0; m_fnh_pat = 0; m_fnh_lay = 0;
        if (!rst_n) model_reset();
        else if (m_state == 0) begin
            if (s) begin
                m_l = int'(cfg_len_row) + 1; m_r = int'(cfg_num_row) + 1;
                m_b = int'(cfg_num_blk) + 1; m_f = int'(cfg_num_frm) + 1;
                m_p = int'(cfg_num_pat) + 1; m_n = int'(cfg_num_lay) + 1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (ab) begin
                m_state = 0; m_k = 0;
            end else if (a) begin
                m_k++;
                m_fnh_frm = (m_k % (m_l * m_r * m_b) == 0);
                m_fnh_pat = (m_k % (m_l * m_r * m_b * m_f) == 0);
                m_fnh_lay = (m_k % (m_l * m_r * m_b * m_f * m_p) == 0);
                if (m_k == m_l * m_r * m_b * m_f * m_p * m_n) begin
                    m_state = 2; m_k = 0;
                end
            end
        end else m_state = 0;
    endtask

    task automatic check_output();
        bit bz;
        int a, r, b, f;
        bz = (m_state == 1);
        a  = m_k % m_l;
        r  = (m_k / m_l) % m_r;
        b  = (m_k / (m_l * m_r)) % m_b;
        f  = (m_k / (m_l * m_r * m_b)) % m_f;
        check("busy", busy, bz);
        check("fetch_req", fetch_req, bz);
        check("done", done, m_state == 2);
        check("frt_row", frt_row, bz && a == 0);
        check("lst_row", lst_row, bz && a == m_l - 1);
        check("frt_blk", frt_blk, bz && b == 0);
        check("lst_blk", lst_blk, bz && r == m_r - 1 && a == m_l - 1);
        check("val_col", val_col, bz && a >= 2);
        check("val_psum", val_psum, bz && r >= 2);
        check("even_frm", even_frm, bz && f % 2 == 0);
        check("fnh_frm", fnh_frm, m_fnh_frm);
        check("fnh_pat", fnh_pat, m_fnh_pat);
        check("fnh_lay", fnh_lay, m_fnh_lay);
`ifdef CTRL_ACT_SEQ_POOL_EN
        check("pool_en", pool_en, bz && b != 0 && f != 0 && a == 0 && r == 0);
        check("pool_val_delta", pool_val_delta, bz && f >= 2);
        check("pool_val_frm", pool_val_frm, bz && f % 2 == 0 && f >= 2);
`else
        check("pool_en", pool_en, 1'b0);
        check("pool_val_delta", pool_val_delta, 1'b0);
        check("pool_val_frm", pool_val_frm, 1'b0);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic apply_stimulus(input bit s, input bit a, input bit ab);
        start = s; fetch_ack = a; abort = ab;
        @(posedge clk);
        model_update(s, a, ab);
        @(negedge clk);
        check_output();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic set_cfg(input int lr, input int nr, input int nb, input int nf, input int np, input int nl);
        cfg_len_row = 5'(lr); cfg_num_row = 5'(nr); cfg_num_blk = 4'(nb);
        cfg_num_frm = 4'(nf); cfg_num_pat = 6'(np); cfg_num_lay = 5'(nl);
    endtask

    // ack_mode: 0 always high, 1 low/high alternating, 2 random. abort_at: fetch number aborted (0 = never).
    task automatic run_cfg(input int ack_mode, input int abort_at, input bit chg_cfg, input bit rnd,
                           output int fetches, output int busy_cycles);
        bit a, ab, s;
        fetches = 0; busy_cycles = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        if (chg_cfg) set_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15),
                             $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 31));
        for (int i = 0; i < 4000 && m_state != 0; i++) begin
            a  = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (i % 2 == 1) : 1'($urandom_range(0, 1));
            ab = (abort_at > 0 && a && fetches == abort_at - 1) || (rnd && $urandom_range(0, 299) == 0);
            s  = rnd && $urandom_range(0, 7) == 0;
            if (busy) busy_cycles++;
            if (fetch_req && a && !ab) fetches++;
            apply_stimulus(s, a, ab);
        end
        check("run_end_idle", busy, 1'b0);
    endtask

    int nf, nb;

    initial begin
        $display("[TB] ctrl_act_seq bench start");
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; fetch_ack = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_output();
        apply_stimulus(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0);

        // Four acts by four rows, ack always high.
        set_cfg(3, 3, 0, 0, 0, 0);
        run_cfg(0, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_4x4", nf, 16);

        // Same shape with ack alternating: sixteen fetches spread over 32 run cycles.
        set_cfg(3, 3, 0, 0, 0, 0);
        run_cfg(1, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_toggle", nf, 16);
        check_int("cycles_toggle", nb, 32);

        // Two blocks of 2x2 over three frames.
        set_cfg(1, 1, 1, 2, 0, 0);
        run_cfg(0, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_frames", nf, 24);

        // Pooling shape: two blocks over four frames.
        set_cfg(1, 1, 1, 3, 0, 0);
        run_cfg(0, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_pool", nf, 32);

        // Abort on the fifth fetch, then a clean full rerun.
        set_cfg(3, 3, 0, 0, 0, 0);
        run_cfg(0, 5, 1'b0, 1'b0, nf, nb);
        check_int("fetches_abort", nf, 4);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        run_cfg(0, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_rerun", nf, 16);

        // Zero-length run, and configuration changed under a running sequence.
        set_cfg(0, 0, 0, 0, 0, 0);
        run_cfg(0, 0, 1'b0, 1'b0, nf, nb);
        check_int("fetches_zero", nf, 1);
        set_cfg(2, 1, 1, 0, 1, 0);
        run_cfg(2, 0, 1'b1, 1'b0, nf, nb);
        check_int("fetches_cfg_change", nf, 24);

        // Reset in the middle of a run drops it without a done pulse.
        set_cfg(3, 3, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (6) apply_stimulus(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0);

        // Randomized shapes with random ack, stray starts and occasional aborts.
        for (int t = 0; t < 6; t++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            run_cfg(2, 0, 1'b0, 1'b1, nf, nb);
            apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_act_seq.md
CTRL_ACT_SEQ -- requirements
Module: ctrl_act_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ROW_W 5 act/row counter width; BLK_W 4 block counter width; FRM_W 4 frame counter width; PAT_W 6 patch counter width; LAY_W 5 layer counter width; COL_SKIP 2 leading columns invalid; ROW_SKIP 2 leading rows invalid.
REQ-002 Ports (name direction width meaning), one per line:
  clk in 1 clock; rst_n in 1 reset, asynchronous, active-low;
  start in 1 pulse, begin run; abort in 1 pulse, stop run;
  cfg_len_row in ROW_W acts per row minus 1; cfg_num_row in ROW_W rows per block minus 1;
  cfg_num_blk in BLK_W blocks per frame minus 1; cfg_num_frm in FRM_W frames per patch minus 1;
  cfg_num_pat in PAT_W patches per layer minus 1; cfg_num_lay in LAY_W layers minus 1;
  fetch_req out 1 activation fetch request; fetch_ack in 1 activation accepted;
  frt_row, lst_row, frt_blk, lst_blk out 1 position flags; val_col, val_psum out 1 validity;
  even_frm out 1 frame counter even; fnh_frm, fnh_pat, fnh_lay out 1 completion pulses;
  busy out 1 run active; done out 1 run-complete pulse;
  pool_en, pool_val_delta, pool_val_frm out 1 pooling controls.

Function
REQ-003 The block SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on the final fetch, DONE->IDLE unconditionally after one cycle, RUN->IDLE on abort.
REQ-004 On start in IDLE, all cfg_* SHALL be latched into shadow registers; cfg_* changes during RUN SHALL have no effect; start outside IDLE SHALL be ignored.
REQ-005 A fetch SHALL occur on each cycle with fetch_req && fetch_ack; fetch_req SHALL equal (state==RUN); counters SHALL hold while fetch_ack is low.
REQ-006 Nested counters act 0..len_row, row 0..num_row, blk 0..num_blk, frm 0..num_frm, pat 0..num_pat, lay 0..num_lay SHALL advance on each fetch, each wrapping to 0 and carrying into the next level when it is at its max and every inner level is at its max.
REQ-007 The fetch with all six counters at max SHALL be the final fetch: counters SHALL return to 0 and state SHALL enter DONE; done SHALL be 1 for exactly the DONE cycle.
REQ-008 Flags SHALL be combinational from counters, gated by busy: frt_row=(act==0); lst_row=(act==len_row); frt_blk=(blk==0); lst_blk=(row==num_row)&&lst_row; val_col=(act>=COL_SKIP); val_psum=(row>=ROW_SKIP); even_frm=~frm[0].
REQ-009 fnh_frm, fnh_pat, fnh_lay SHALL be registered one-cycle pulses in the cycle after the fetch that wraps blk, frm, pat respectively to 0; on the final fetch all three SHALL pulse together with done.
REQ-010 busy SHALL be 1 in RUN only.
REQ-011 Abort SHALL take priority over fetch in the same cycle: counters SHALL clear to 0 on the next edge, no fnh_* or done pulse SHALL be produced.
REQ-012 Zero-length configuration (all cfg_*=0) SHALL complete after exactly one fetch.

Reset
REQ-013 rst_n low SHALL asynchronously force state IDLE, all counters and shadow registers 0, and all outputs 0.
REQ-014 Reset asserted mid-run SHALL discard the run; no done pulse SHALL follow deassertion.

Configuration
REQ-015 Macro CTRL_ACT_SEQ_POOL_EN defined: pool_en=busy&&(blk!=0)&&(frm!=0)&&(act==0)&&(row==0); pool_val_delta=busy&&(frm>=2); pool_val_frm=busy&&~frm[0]&&(frm>=2).
REQ-016 Macro CTRL_ACT_SEQ_POOL_EN undefined: the three pool outputs SHALL be tied 0, no pooling logic SHALL be present, and the ports SHALL remain.

Verification
REQ-017 len_row=3, num_row=3, other cfg=0, ack held 1 -> 16 fetches, lst_row high on fetches 4,8,12,16, done on cycle after fetch 16.
REQ-018 Same cfg, ack toggles 1/0 -> 16 fetches over 32 cycles, counters frozen on ack-low cycles.
REQ-019 len_row=1, num_row=1, num_blk=1, num_frm=2 -> fnh_frm after fetches 8,16,24; fnh_pat and done together after fetch 24; even_frm 1,0,1 per frame.
REQ-020 Abort asserted with ack at fetch 5 -> IDLE next cycle, busy 0, counters 0, no done; new start runs a full sequence.
REQ-021 All cfg=0 -> single fetch, done plus fnh_frm/pat/lay the next cycle; cfg change mid-run -> fetch count unchanged.
REQ-022 POOL_EN defined, num_blk=1, num_frm=3 -> pool_en only at act=row=0 of blk 1 in frames 1..3; pool_val_frm high in frame 2 only.
